// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared request-type and arbiter state encodings
package mem_arbiter_pkg;

  localparam logic MEM_REQ_READ  = 1'b0;
  localparam logic MEM_REQ_WRITE = 1'b1;

  typedef enum logic [2:0] {
    ARB_IDLE     = 3'd0,
    ARB_ISSUE_IF = 3'd1,
    ARB_ISSUE_DM = 3'd2,
    ARB_WAIT_IF  = 3'd3,
    ARB_WAIT_DM  = 3'd4
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-outstanding memory port arbiter, data priority with bounded fetch starvation
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W        = 32,
  parameter int MAX_DM_STREAK = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [ADDR_W-1:0] if_req_addr,
  output logic              if_resp_valid,
  output logic [31:0]       if_resp_data,
  input  logic              dm_req_valid,
  output logic              dm_req_ready,
  input  logic              dm_req_type,
  input  logic [ADDR_W-1:0] dm_req_addr,
  input  logic [31:0]       dm_req_wdata,
  input  logic [3:0]        dm_req_wmask,
  output logic              dm_resp_valid,
  output logic [31:0]       dm_resp_data,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_type,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [31:0]       mem_req_wdata,
  output logic [3:0]        mem_req_wmask,
  input  logic              mem_resp_valid,
  input  logic [31:0]       mem_resp_data,
  output logic              proto_err
);

  localparam int STREAK_W = $clog2(MAX_DM_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DM_STREAK);

  arb_state_t          state_q;
  arb_state_t          state_d;
  logic [STREAK_W-1:0] streak_q;
  logic                streak_full;
  logic                if_acc;
  logic                dm_acc;
  logic                req_type_q;
  logic [ADDR_W-1:0]   req_addr_q;
  logic [31:0]         req_wdata_q;
  logic [3:0]          req_wmask_q;

  assign streak_full = (streak_q == STREAK_MAX);
  assign if_acc      = if_req_valid && if_req_ready;
  assign dm_acc      = dm_req_valid && dm_req_ready;

  assign mem_req_type  = req_type_q;
  assign mem_req_addr  = req_addr_q;
  assign mem_req_wdata = req_wdata_q;
  assign mem_req_wmask = req_wmask_q;

  // State register; reset aborts any transaction in flight
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ARB_IDLE;
    else          state_q <= state_d;
  end

  // Next state, readies and memory request valid; readies are held low while in reset
  always_comb begin
    state_d       = state_q;
    if_req_ready  = 1'b0;
    dm_req_ready  = 1'b0;
    mem_req_valid = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        dm_req_ready = reset_n && !(if_req_valid && streak_full);
        if_req_ready = reset_n && (!dm_req_valid || streak_full);
        if (dm_req_valid && dm_req_ready)      state_d = ARB_ISSUE_DM;
        else if (if_req_valid && if_req_ready) state_d = ARB_ISSUE_IF;
      end
      ARB_ISSUE_IF: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_d = ARB_WAIT_IF;
      end
      ARB_ISSUE_DM: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_d = ARB_WAIT_DM;
      end
      ARB_WAIT_IF: if (mem_resp_valid) state_d = ARB_IDLE;
      ARB_WAIT_DM: if (mem_resp_valid) state_d = ARB_IDLE;
      default:     state_d = ARB_IDLE;
    endcase
  end

  // Consecutive DM grants taken while fetch was waiting; saturates at the limit
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      streak_q <= '0;
    end else if (dm_acc && if_req_valid) begin
      if (!streak_full) streak_q <= streak_q + STREAK_W'(1);
    end else if (if_acc || (state_q == ARB_IDLE && !if_req_valid)) begin
      streak_q <= '0;
    end
  end

  // Request capture, response routing and sticky protocol error
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_type_q    <= MEM_REQ_READ;
      req_addr_q    <= '0;
      req_wdata_q   <= '0;
      req_wmask_q   <= '0;
      if_resp_valid <= 1'b0;
      if_resp_data  <= '0;
      dm_resp_valid <= 1'b0;
      dm_resp_data  <= '0;
      proto_err     <= 1'b0;
    end else begin
      if_resp_valid <= 1'b0;
      dm_resp_valid <= 1'b0;
      if (dm_acc) begin
        req_type_q  <= dm_req_type;
        req_addr_q  <= dm_req_addr;
        req_wdata_q <= dm_req_wdata;
        req_wmask_q <= (dm_req_type == MEM_REQ_WRITE) ? dm_req_wmask : 4'b0000;
      end else if (if_acc) begin
        req_type_q  <= MEM_REQ_READ;
        req_addr_q  <= if_req_addr;
        req_wdata_q <= '0;
        req_wmask_q <= 4'b0000;
      end
      if (mem_resp_valid) begin
        case (state_q)
          ARB_WAIT_IF: begin
            if_resp_valid <= 1'b1;
            if_resp_data  <= mem_resp_data;
          end
          ARB_WAIT_DM: begin
            dm_resp_valid <= 1'b1;
            dm_resp_data  <= (req_type_q == MEM_REQ_WRITE) ? 32'h0 : mem_resp_data;
          end
          default: proto_err <= 1'b1;
        endcase
      end
    end
  end

endmodule
